// File: rtl/timer_m_pkg.sv
// Shared types and helpers for the DMG-style timer peripheral.
package timer_m_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OVF,
      RELOAD
   } timer_state_t;

   localparam logic [1:0] OFF_DIV  = 2'd0;
   localparam logic [1:0] OFF_TIMA = 2'd1;
   localparam logic [1:0] OFF_TMA  = 2'd2;
   localparam logic [1:0] OFF_TAC  = 2'd3;

   // Counter bit whose falling edge clocks TIMA for a given TAC clock select.
   function automatic logic [3:0] tac_bit_sel(input logic [1:0] clk_sel);
      case (clk_sel)
         2'b00:   return 4'd9;
         2'b01:   return 4'd3;
         2'b10:   return 4'd5;
         default: return 4'd7;
      endcase
   endfunction

endpackage

// File: rtl/timer_m_if.sv
// CPU memory-bus view of the timer: the CPU is master, the timer responds.
interface timer_m_if;
   logic [15:0] addr;
   logic [7:0]  d_in;
   logic        write;
   logic [7:0]  d_out;
   logic        sel;
   logic        irq;

   modport master (output addr, output d_in, output write,
                   input d_out, input sel, input irq);
   modport slave  (input addr, input d_in, input write,
                   output d_out, output sel, output irq);
endinterface

// File: rtl/timer_m_div_counter.sv
// Free-running divider counter plus the falling-edge detector that clocks TIMA.
import timer_m_pkg::*;

module div_counter_m #(
   parameter int TICKS_PER_CLK = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear_i,
   input  logic [2:0] tac_i,
   output logic [7:0] div_o,
   output logic       tick_o
);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;
   logic        prev_q;
   logic        sig;

   assign cnt_d = clear_i ? 16'h0000 : cnt_q + 16'(TICKS_PER_CLK);

   // tac_i already reflects a TAC write in flight, so enable/select changes
   // can produce an extra falling edge exactly like the original hardware.
   assign sig    = tac_i[2] & cnt_d[tac_bit_sel(tac_i[1:0])];
   assign tick_o = prev_q & ~sig;
   assign div_o  = cnt_q[15:8];

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q  <= 16'h0000;
         prev_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         prev_q <= sig;
      end
   end

endmodule

// File: rtl/timer_m.sv
// DIV/TIMA/TMA/TAC timer registers with delayed TIMA reload and interrupt pulse.
import timer_m_pkg::*;

module timer_m #(
   parameter logic [15:0] BASE          = 16'hFF04,
   parameter int          TICKS_PER_CLK = 4
) (
   input  logic     clk,
   input  logic     rst,
   timer_m_if.slave bus
);

   logic [7:0]   tima_q;
   logic [7:0]   tma_q;
   logic [2:0]   tac_q;
   logic         irq_q;
   timer_state_t state_q;

   logic [15:0]  off;
   logic         hit;
   logic         wr_div, wr_tima, wr_tma, wr_tac;
   logic [2:0]   tac_eff;
   logic [7:0]   div_val;
   logic         tick;

   assign off     = bus.addr - BASE;
   assign hit     = (off[15:2] == 14'd0);
   assign wr_div  = bus.write & hit & (off[1:0] == OFF_DIV);
   assign wr_tima = bus.write & hit & (off[1:0] == OFF_TIMA);
   assign wr_tma  = bus.write & hit & (off[1:0] == OFF_TMA);
   assign wr_tac  = bus.write & hit & (off[1:0] == OFF_TAC);
   assign tac_eff = wr_tac ? bus.d_in[2:0] : tac_q;

   div_counter_m #(
      .TICKS_PER_CLK(TICKS_PER_CLK)
   ) u_div (
      .clk    (clk),
      .rst    (rst),
      .clear_i(wr_div),
      .tac_i  (tac_eff),
      .div_o  (div_val),
      .tick_o (tick)
   );

   assign bus.sel = hit;
   assign bus.irq = irq_q;

   always_comb begin
      bus.d_out = 8'hFF;
      if (hit) begin
         case (off[1:0])
            OFF_DIV:  bus.d_out = div_val;
            OFF_TIMA: bus.d_out = tima_q;
            OFF_TMA:  bus.d_out = tma_q;
            default:  bus.d_out = {5'b11111, tac_q};
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         tima_q  <= 8'h00;
         tma_q   <= 8'h00;
         tac_q   <= 3'b000;
         irq_q   <= 1'b0;
         state_q <= IDLE;
      end else begin
         irq_q <= 1'b0;
         if (wr_tma) tma_q <= bus.d_in;
         if (wr_tac) tac_q <= bus.d_in[2:0];
         case (state_q)
            IDLE: begin
               if (wr_tima) begin
                  tima_q <= bus.d_in;
               end else if (tick) begin
                  if (tima_q == 8'hFF) begin
                     tima_q  <= 8'h00;
                     state_q <= OVF;
                  end else begin
                     tima_q <= tima_q + 8'd1;
                  end
               end
            end
            // TIMA sits at 00 for this one cycle; a CPU write here cancels the reload.
            OVF: begin
               if (wr_tima) begin
                  tima_q  <= bus.d_in;
                  state_q <= IDLE;
               end else begin
                  tima_q  <= wr_tma ? bus.d_in : tma_q;
                  irq_q   <= 1'b1;
                  state_q <= RELOAD;
               end
            end
            RELOAD: begin
               state_q <= IDLE;
               if (wr_tma) begin
                  tima_q <= bus.d_in;
               end else if (tick) begin
                  if (tima_q == 8'hFF) begin
                     tima_q  <= 8'h00;
                     state_q <= OVF;
                  end else begin
                     tima_q <= tima_q + 8'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_timer_m.sv
// Directed scoreboard bench for timer_m: expectations queued per cycle, checked mid-cycle.
module tb_timer_m;

   logic clk = 1'b0;
   logic rst;

   timer_m_if bus ();

   timer_m #(
      .BASE         (16'hFF04),
      .TICKS_PER_CLK(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      int         fld;
      logic [7:0] val;
   } sb_t;

   sb_t sb_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
   endtask

   // One bus cycle: drive inputs, queue expectations, compare at negedge, commit at posedge.
   task automatic cyc(input string tag, input logic [15:0] a, input logic w,
                      input logic [7:0] d, input int exp_d, input int exp_irq);
      sb_t  e;
      logic s_exp;
      bus.addr  = a;
      bus.write = w;
      bus.d_in  = d;
      s_exp = (a >= 16'hFF04) && (a <= 16'hFF07);
      if (exp_d >= 0) begin
         e.tag = {tag, ".dout"}; e.fld = 0; e.val = exp_d[7:0];
         sb_q.push_back(e);
      end
      e.tag = {tag, ".sel"}; e.fld = 1; e.val = {7'b0, s_exp};
      sb_q.push_back(e);
      if (exp_irq >= 0) begin
         e.tag = {tag, ".irq"}; e.fld = 2; e.val = exp_irq[7:0];
         sb_q.push_back(e);
      end
      @(negedge clk);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         case (e.fld)
            0:       check_val(e.tag, bus.d_out, e.val);
            1:       check_val(e.tag, {7'b0, bus.sel}, e.val);
            default: check_val(e.tag, {7'b0, bus.irq}, e.val);
         endcase
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      cyc("rst_a", 16'hFF05, 1'b0, 8'h00, -1, -1);
      cyc("rst_tima", 16'hFF05, 1'b0, 8'h00, 8'h00, 0);
      cyc("rst_tac", 16'hFF07, 1'b0, 8'h00, 8'hF8, 0);
      rst = 1'b1;
   endtask

   // Edges E1..E3 after reset; TAC=05 at E3 makes the first tick land on E4, then every 4.
   task automatic setup(input string tag, input logic [7:0] tima, input logic [7:0] tma);
      do_reset();
      cyc({tag, "_s_tma"},  16'hFF06, 1'b1, tma,   8'h00, 0);
      cyc({tag, "_s_tima"}, 16'hFF05, 1'b1, tima,  8'h00, 0);
      cyc({tag, "_s_tac"},  16'hFF07, 1'b1, 8'h05, 8'hF8, 0);
   endtask

   // TIMA after edge j for setup(FE, 42) with no interference.
   function automatic int ovf_exp(input int j);
      if (j == 3)       return 8'hFE;
      else if (j <= 7)  return 8'hFF;
      else if (j == 8)  return 8'h00;
      else if (j <= 11) return 8'h42;
      else              return 8'h43;
   endfunction

   initial begin
      rst       = 1'b0;
      bus.addr  = 16'h0000;
      bus.write = 1'b0;
      bus.d_in  = 8'h00;
      @(posedge clk);
      #1;

      // Test 1: TIMA every 4 clks, DIV every 64 clks.
      setup("t1", 8'h00, 8'h00);
      for (int k = 4; k <= 130; k++) begin
         if (k == 64 || k == 65 || k == 128 || k == 129)
            cyc($sformatf("t1_div_k%0d", k), 16'hFF04, 1'b0, 8'h00, (k - 1) / 64, 0);
         else
            cyc($sformatf("t1_tima_k%0d", k), 16'hFF05, 1'b0, 8'h00, ((k - 1) / 4) % 256, 0);
      end

      // Test 2: overflow, one-cycle 00, reload 42, irq aligned with RELOAD.
      setup("t2", 8'hFE, 8'h42);
      for (int k = 4; k <= 14; k++)
         cyc($sformatf("t2_k%0d", k), 16'hFF05, 1'b0, 8'h00, ovf_exp(k - 1), (k - 1 == 9) ? 1 : 0);

      // Test 3: TIMA write during OVF cancels reload and irq.
      setup("t3", 8'hFE, 8'h42);
      for (int k = 4; k <= 8; k++)
         cyc($sformatf("t3_k%0d", k), 16'hFF05, 1'b0, 8'h00, ovf_exp(k - 1), 0);
      cyc("t3_wr_ovf", 16'hFF05, 1'b1, 8'h10, 8'h00, 0);
      for (int k = 10; k <= 14; k++)
         cyc($sformatf("t3_k%0d", k), 16'hFF05, 1'b0, 8'h00, (k >= 13) ? 8'h11 : 8'h10, 0);

      // Test 4a: TIMA write during RELOAD is ignored.
      setup("t4a", 8'hFE, 8'h42);
      for (int k = 4; k <= 9; k++)
         cyc($sformatf("t4a_k%0d", k), 16'hFF05, 1'b0, 8'h00, ovf_exp(k - 1), 0);
      cyc("t4a_wr_rel", 16'hFF05, 1'b1, 8'h99, 8'h42, 1);
      cyc("t4a_k11", 16'hFF05, 1'b0, 8'h00, 8'h42, 0);
      cyc("t4a_k12", 16'hFF05, 1'b0, 8'h00, 8'h42, 0);
      cyc("t4a_k13", 16'hFF05, 1'b0, 8'h00, 8'h43, 0);

      // Test 4b: TMA write during RELOAD lands in both TMA and TIMA.
      setup("t4b", 8'hFE, 8'h42);
      for (int k = 4; k <= 9; k++)
         cyc($sformatf("t4b_k%0d", k), 16'hFF05, 1'b0, 8'h00, ovf_exp(k - 1), 0);
      cyc("t4b_wr_tma", 16'hFF06, 1'b1, 8'h77, 8'h42, 1);
      cyc("t4b_tima", 16'hFF05, 1'b0, 8'h00, 8'h77, 0);
      cyc("t4b_tma",  16'hFF06, 1'b0, 8'h00, 8'h77, 0);
      cyc("t4b_inc",  16'hFF05, 1'b0, 8'h00, 8'h78, 0);

      // Test 5a: DIV write while the selected bit is high gives an extra tick.
      setup("t5a", 8'h00, 8'h00);
      for (int k = 4; k <= 6; k++)
         cyc($sformatf("t5a_k%0d", k), 16'hFF05, 1'b0, 8'h00, (k - 1) / 4, 0);
      cyc("t5a_wr_div", 16'hFF04, 1'b1, 8'hA5, 8'h00, 0);
      for (int k = 8; k <= 12; k++)
         cyc($sformatf("t5a_k%0d", k), 16'hFF05, 1'b0, 8'h00, (k == 12) ? 8'h03 : 8'h02, 0);

      // Test 5b: disabling TAC while the selected bit is high also ticks.
      setup("t5b", 8'h00, 8'h00);
      for (int k = 4; k <= 6; k++)
         cyc($sformatf("t5b_k%0d", k), 16'hFF05, 1'b0, 8'h00, (k - 1) / 4, 0);
      cyc("t5b_wr_tac", 16'hFF07, 1'b1, 8'h01, 8'hFD, 0);
      for (int k = 8; k <= 12; k++)
         cyc($sformatf("t5b_k%0d", k), 16'hFF05, 1'b0, 8'h00, 8'h02, 0);
      cyc("t5b_tac", 16'hFF07, 1'b0, 8'h00, 8'hF9, 0);

      // Test 6: unmapped addresses and TAC read-back.
      cyc("t6_ff03", 16'hFF03, 1'b0, 8'h00, 8'hFF, -1);
      cyc("t6_ff08", 16'hFF08, 1'b0, 8'h00, 8'hFF, -1);
      cyc("t6_wr_ff", 16'hFF07, 1'b1, 8'hFF, 8'hF9, -1);
      cyc("t6_tac_ff", 16'hFF07, 1'b0, 8'h00, 8'hFF, -1);
      cyc("t6_wr_00", 16'hFF07, 1'b1, 8'h00, 8'hFF, -1);
      cyc("t6_tac_00", 16'hFF07, 1'b0, 8'h00, 8'hF8, -1);
      cyc("t6_wr_out", 16'hFF03, 1'b1, 8'h07, 8'hFF, -1);
      cyc("t6_tac_kept", 16'hFF07, 1'b0, 8'h00, 8'hF8, -1);

      // Test 7: TIMA write in IDLE beats a simultaneous increment.
      setup("t7", 8'h00, 8'h00);
      cyc("t7_wr_tick", 16'hFF05, 1'b1, 8'h50, 8'h00, 0);
      for (int k = 5; k <= 9; k++)
         cyc($sformatf("t7_k%0d", k), 16'hFF05, 1'b0, 8'h00, (k == 9) ? 8'h51 : 8'h50, 0);

      // Test 8: reset during OVF suppresses reload and irq.
      setup("t8", 8'hFE, 8'h42);
      for (int k = 4; k <= 8; k++)
         cyc($sformatf("t8_k%0d", k), 16'hFF05, 1'b0, 8'h00, ovf_exp(k - 1), 0);
      rst = 1'b0;
      cyc("t8_rst_ovf", 16'hFF05, 1'b0, 8'h00, 8'h00, 0);
      rst = 1'b1;
      cyc("t8_after", 16'hFF05, 1'b0, 8'h00, 8'h00, 0);
      cyc("t8_tma", 16'hFF06, 1'b0, 8'h00, 8'h00, 0);
      cyc("t8_quiet", 16'hFF05, 1'b0, 8'h00, 8'h00, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/timer_m.md
Name: timer_m

Overview:
- Memory-mapped timer peripheral; the responder side of the CPU memory bus (addr / CPU write data / CPU read data / write strobe).
- Implements the DMG divider and timer registers: DIV, TIMA, TMA, TAC.
- Requests the timer interrupt on TIMA overflow.
- Sits beside the memory and I/O responders; a top-level read mux uses `sel` to choose this block's read data.

Parameters:
BASE, 16'hFF04, address of DIV; TIMA/TMA/TAC at BASE+1..BASE+3.
TICKS_PER_CLK, 4, internal counter increment per clk (one clk = one M-cycle).

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-low reset.
addr  input  16  bus address from CPU, valid whole cycle.
d_in  input  8  write data from CPU.
write  input  1  write strobe; the write commits at the end of the cycle (posedge).
d_out  output  8  read data, combinational on addr.
sel  output  1  high when addr is in BASE..BASE+3.
irq  output  1  registered one-cycle timer interrupt request pulse.

Behaviour:
- Reset (rst==0 at posedge): cnt=0, TIMA=0, TMA=0, TAC=0, state=IDLE, irq=0, edge register=0.
- While in reset, d_out still decodes addr.
- cnt: 16-bit internal counter.
  - cnt_next = (write to DIV) ? 0 : cnt + TICKS_PER_CLK, wrapping mod 2^16.
  - A DIV write clears cnt regardless of d_in.
- Reads, combinational, no latency, showing pre-write values:
  - DIV returns cnt[15:8].
  - TIMA returns TIMA; TMA returns TMA.
  - TAC returns {5'b11111, TAC[2:0]}.
  - Unmapped addresses: d_out=8'hFF, sel=0.
- Timer input: sig = TAC[2] & cnt_next[b].
  - b = 9, 3, 5, 7 for TAC[1:0] = 00, 01, 10, 11.
  - sig is computed with the TAC value being written this cycle, if any.
  - prev <= sig every cycle.
  - Increment event when prev==1 and sig==0 (falling edge).
  - Consequently DIV writes and TAC writes can cause a spurious increment; this is intentional and DMG-accurate.
- Overflow FSM, states IDLE, OVF, RELOAD:
  - IDLE: increment event with TIMA==FF: TIMA<=00, go OVF. Any other increment: TIMA<=TIMA+1.
  - OVF (exactly one cycle, TIMA reads 00):
    - CPU write to TIMA: TIMA<=d_in, reload cancelled, no irq, go IDLE.
    - Otherwise: TIMA<=TMA, irq<=1, go RELOAD. If TMA is written this cycle, the new value is loaded.
    - Increment events in OVF are dropped.
  - RELOAD (one cycle, irq high this cycle):
    - TIMA writes are ignored.
    - TMA write: TMA<=d_in and TIMA<=d_in.
    - Increment events are processed as in IDLE.
    - Next state IDLE, irq<=0.
- Writes in IDLE: TIMA write beats a simultaneous increment (written value kept, no overflow).
- TMA/TAC writes: take effect at the posedge; TAC stores d_in[2:0].
- Writes outside the window are ignored.
- irq is never high for more than one consecutive cycle.
- Reset mid-overflow: state returns to IDLE and no irq is emitted.

Decomposition:
- Shared package holds:
  - timer_state_t (IDLE, OVF, RELOAD).
  - Register offset constants (OFF_DIV=0, OFF_TIMA=1, OFF_TMA=2, OFF_TAC=3).
  - A function mapping TAC[1:0] to a cnt bit index.
- One natural sub-module, div_counter_m: owns cnt, the DIV-write clear, the bit select and the falling-edge detector; outputs cnt[15:8] and a tick pulse.
- timer_m keeps TIMA/TMA/TAC, the FSM and the bus decode.

Test Plan:
1. Reset, then write TAC=05 (enable, bit 3); poll TIMA -> TIMA increments once every 4 clks; DIV increments once every 64 clks.
2. TIMA=FE, TMA=0x42, TAC=05, run -> TIMA reads FF, then 00 for exactly one cycle, then 0x42; irq high for exactly one clk, aligned with the RELOAD cycle.
3. Same setup; write TIMA=0x10 during the OVF cycle -> TIMA=0x10, no reload, irq stays 0.
4. Same setup; write TIMA=0x99 during RELOAD -> ignored, TIMA=0x42. Separately, write TMA=0x77 during RELOAD -> TIMA=0x77 and TMA=0x77.
5. TAC=05, advance until cnt[3]=1, then write DIV -> cnt cleared and TIMA increments by 1 (falling edge). The same cycle with TAC written to 0x01 (disable) -> TIMA +1.
6. Read addr 0xFF03 and 0xFF08 -> d_out=FF, sel=0. Read TAC after writing 0xFF -> 0xFF; after writing 0x00 -> 0xF8.
